// File: rtl/rx_fifo_axis.sv
// rx_fifo_axis: receive-side FIFO between receiver_axis and downstream logic.
// Upstream words are accepted whenever space exists; when full the word is
// dropped. Optional sticky drop flag is built when RX_FIFO_AXIS_OVERFLOW_EN
// is defined; otherwise overflow is tied low and overflow_clear is ignored.
module rx_fifo_axis #(
    parameter int unsigned WORD_WIDTH = 32'd8,
    parameter int unsigned DEPTH      = 32'd16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_WIDTH-1:0]        din_axis_tdata,
    input  logic                         din_axis_tvalid,
    output logic                         din_axis_tready,
    output logic [WORD_WIDTH-1:0]        dout_axis_tdata,
    output logic                         dout_axis_tvalid,
    input  logic                         dout_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         overflow_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_en;
    logic                  rd_en;

    assign din_axis_tready  = (count_q != CW'(DEPTH));
    assign dout_axis_tvalid = (count_q != '0);
    assign dout_axis_tdata  = mem_q[rd_ptr_q];
    assign count            = count_q;

    // Handshake decode, pointer advance and occupancy update
    always_comb begin
        wr_en    = din_axis_tvalid && din_axis_tready;
        rd_en    = dout_axis_tvalid && dout_axis_tready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_axis_tdata;
        end
    end

`ifdef RX_FIFO_AXIS_OVERFLOW_EN
    logic overflow_q, overflow_d;
    logic drop;

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_comb begin
        drop       = din_axis_tvalid && !din_axis_tready;
        overflow_d = overflow_q;
        if (overflow_clear) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Drop flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_overflow_clear;

    assign unused_overflow_clear = overflow_clear;
    assign overflow              = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_axis.sv
// Self-checking bench for rx_fifo_axis (DEPTH=16, 8-bit words).
module tb_rx_fifo_axis;

    localparam int unsigned WW    = 8;
    localparam int unsigned DEPTH = 16;
`ifdef RX_FIFO_AXIS_OVERFLOW_EN
    localparam logic OVF_SET = 1'b1;
`else
    localparam logic OVF_SET = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] din_axis_tdata;
    logic          din_axis_tvalid;
    logic          din_axis_tready;
    logic [WW-1:0] dout_axis_tdata;
    logic          dout_axis_tvalid;
    logic          dout_axis_tready;
    logic [4:0]    count;
    logic          overflow;
    logic          overflow_clear;

    int vectors = 0;
    int errors  = 0;
    logic [WW-1:0] sb[$];

    rx_fifo_axis #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .din_axis_tdata   (din_axis_tdata),
        .din_axis_tvalid  (din_axis_tvalid),
        .din_axis_tready  (din_axis_tready),
        .dout_axis_tdata  (dout_axis_tdata),
        .dout_axis_tvalid (dout_axis_tvalid),
        .dout_axis_tready (dout_axis_tready),
        .count            (count),
        .overflow         (overflow),
        .overflow_clear   (overflow_clear)
    );

    always #5 clk = ~clk;

    // Scoreboard: at the falling edge, predict the handshakes of the coming
    // rising edge from the model occupancy, check flags and popped data.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            automatic bit m_full  = (sb.size() == DEPTH);
            automatic bit m_empty = (sb.size() == 0);
            automatic logic [WW-1:0] exp_word;
            vectors++;
            if (din_axis_tready !== !m_full) begin
                errors++;
                $display("FAIL tready: got %b expected %b", din_axis_tready, !m_full);
            end
            vectors++;
            if (dout_axis_tvalid !== !m_empty) begin
                errors++;
                $display("FAIL tvalid: got %b expected %b", dout_axis_tvalid, !m_empty);
            end
            if (!m_empty && dout_axis_tready) begin
                exp_word = sb.pop_front();
                vectors++;
                if (dout_axis_tdata !== exp_word) begin
                    errors++;
                    $display("FAIL data: got %h expected %h", dout_axis_tdata, exp_word);
                end
            end
            if (din_axis_tvalid && !m_full) begin
                sb.push_back(din_axis_tdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        dout_axis_tready = 1'b1;
        for (int k = 0; k < 40 && count != 0; k++) step();
        dout_axis_tready = 1'b0;
        vectors++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL %s_drain: count %0d expected 0", name, count);
        end
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb: %0d words expected but not emitted", name, sb.size());
        end
    endtask

    task automatic fill16(input logic [WW-1:0] base);
        for (int i = 0; i < 16; i++) begin
            din_axis_tdata  = base + WW'(i);
            din_axis_tvalid = 1'b1;
            step();
        end
        din_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (dout_axis_tvalid !== 1'b0 || din_axis_tready !== 1'b1 || count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: tvalid=%b tready=%b count=%0d ovf=%b expected 0 1 0 0",
                     dout_axis_tvalid, din_axis_tready, count, overflow);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        din_axis_tdata  = 8'hA5;
        din_axis_tvalid = 1'b1;
        step();
        din_axis_tvalid = 1'b0;
        vectors++;
        if (dout_axis_tvalid !== 1'b1 || dout_axis_tdata !== 8'hA5 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_write: tvalid=%b data=%h count=%0d expected 1 a5 1",
                     dout_axis_tvalid, dout_axis_tdata, count);
        end
        dout_axis_tready = 1'b1;
        step();
        dout_axis_tready = 1'b0;
        vectors++;
        if (dout_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_read: tvalid=%b count=%0d expected 0 0", dout_axis_tvalid, count);
        end
    endtask

    task automatic test_fill_order();
        fill16(8'h00);
        vectors++;
        if (count !== 5'd16 || din_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL fill: count=%0d tready=%b expected 16 0", count, din_axis_tready);
        end
        drain("fill");
    endtask

    task automatic test_overflow();
        fill16(8'h30);
        din_axis_tdata  = 8'hFF;
        din_axis_tvalid = 1'b1;
        step();
        din_axis_tvalid = 1'b0;
        vectors++;
        if (overflow !== OVF_SET || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d expected %b 16", overflow, count, OVF_SET);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_full_rw();
        din_axis_tdata   = 8'h55;
        din_axis_tvalid  = 1'b1;
        dout_axis_tready = 1'b1;
        step();
        din_axis_tvalid  = 1'b0;
        dout_axis_tready = 1'b0;
        vectors++;
        if (count !== 5'd15 || overflow !== OVF_SET || din_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL full_rw: count=%0d ovf=%b tready=%b expected 15 %b 1",
                     count, overflow, din_axis_tready, OVF_SET);
        end
        // Drop and clear together: the drop must win
        fill16(8'h60);
        din_axis_tdata  = 8'hEE;
        din_axis_tvalid = 1'b1;
        overflow_clear  = 1'b1;
        step();
        din_axis_tvalid = 1'b0;
        overflow_clear  = 1'b0;
        vectors++;
        if (overflow !== OVF_SET) begin
            errors++;
            $display("FAIL clear_vs_drop: ovf=%b expected %b", overflow, OVF_SET);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        drain("full_rw");
    endtask

    task automatic test_back_to_back();
        dout_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din_axis_tdata  = WW'(i);
            din_axis_tvalid = 1'b1;
            step();
            vectors++;
            if (count > 5'd1) begin
                errors++;
                $display("FAIL wrap_count: count=%0d at word %0d expected <=1", count, i);
            end
        end
        din_axis_tvalid = 1'b0;
        step();
        dout_axis_tready = 1'b0;
        vectors++;
        if (count !== 5'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: count=%0d pending=%0d expected 0 0", count, sb.size());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            din_axis_tdata  = 8'hC0 + WW'(i);
            din_axis_tvalid = 1'b1;
            step();
        end
        din_axis_tvalid = 1'b0;
        vectors++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL arst_pre: count=%0d expected 5", count);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (dout_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL arst_immediate: tvalid=%b count=%0d expected 0 0", dout_axis_tvalid, count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        vectors++;
        if (din_axis_tready !== 1'b1 || count !== 5'd0 || dout_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: tready=%b count=%0d tvalid=%b expected 1 0 0",
                     din_axis_tready, count, dout_axis_tvalid);
        end
    endtask

    initial begin
        rst              = 1'b0;
        din_axis_tdata   = '0;
        din_axis_tvalid  = 1'b0;
        dout_axis_tready = 1'b0;
        overflow_clear   = 1'b0;
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_full_rw();
        test_back_to_back();
        test_async_reset();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
